// File: rtl/control.sv
// control: multicycle main controller for the 8-bit MIPS-subset processor.
// Moore machine: every datapath select and write enable is decoded from the
// state register alone. The opcode only steers the next-state choice out of
// DECODE and MEMADR.
module control (
    input  logic        ph1,
    input  logic        reset,
    input  logic        Zero,
    input  logic [31:0] Instruction,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        IorD,
    output logic        IRWrite0,
    output logic        IRWrite1,
    output logic        IRWrite2,
    output logic        IRWrite3,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] w_op;

    // Branch gating with Zero happens in the datapath; the remaining
    // instruction bits belong to the datapath and ALU-control block.
    logic w_unused;
    assign w_unused = ^{Zero, Instruction[25:0]};

    assign w_op = Instruction[31:26];

    // State register; a low reset forces FETCH1 immediately.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH1;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing; unknown opcodes and unused encodings go to FETCH1.
    always_comb begin
        w_next_state = FETCH1;
        case (r_state)
            FETCH1:  w_next_state = FETCH2;
            FETCH2:  w_next_state = FETCH3;
            FETCH3:  w_next_state = FETCH4;
            FETCH4:  w_next_state = DECODE;
            DECODE: begin
                case (w_op)
                    OP_LB, OP_SB: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = RTYPEEX;
                    OP_BEQ:       w_next_state = BEQEX;
                    OP_J:         w_next_state = JEX;
                    OP_ADDI:      w_next_state = ADDIEX;
                    default:      w_next_state = FETCH1;
                endcase
            end
            MEMADR: begin
                if (w_op == OP_LB) begin
                    w_next_state = LBRD;
                end else if (w_op == OP_SB) begin
                    w_next_state = SBWR;
                end else begin
                    w_next_state = FETCH1;
                end
            end
            LBRD:    w_next_state = LBWR;
            RTYPEEX: w_next_state = RTYPEWR;
            ADDIEX:  w_next_state = ADDIWR;
            default: w_next_state = FETCH1;
        endcase
    end

    // Moore output decode: everything defaults to 0, each state raises its own.
    always_comb begin
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        MemtoReg    = 1'b0;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        IRWrite0    = 1'b0;
        IRWrite1    = 1'b0;
        IRWrite2    = 1'b0;
        IRWrite3    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (r_state)
            FETCH1: begin
                MemRead = 1'b1; IRWrite3 = 1'b1; ALUSrcB = 2'b01; PCWrite = 1'b1;
            end
            FETCH2: begin
                MemRead = 1'b1; IRWrite2 = 1'b1; ALUSrcB = 2'b01; PCWrite = 1'b1;
            end
            FETCH3: begin
                MemRead = 1'b1; IRWrite1 = 1'b1; ALUSrcB = 2'b01; PCWrite = 1'b1;
            end
            FETCH4: begin
                MemRead = 1'b1; IRWrite0 = 1'b1; ALUSrcB = 2'b01; PCWrite = 1'b1;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEMADR: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10;
            end
            LBRD: begin
                MemRead = 1'b1; IorD = 1'b1;
            end
            LBWR: begin
                RegWrite = 1'b1; MemtoReg = 1'b1;
            end
            SBWR: begin
                MemWrite = 1'b1; IorD = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1; ALUOp = 2'b10;
            end
            RTYPEWR: begin
                RegDst = 1'b1; RegWrite = 1'b1;
            end
            BEQEX: begin
                ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01;
            end
            JEX: begin
                PCWrite = 1'b1; PCSource = 2'b10;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10;
            end
            ADDIWR: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control.sv
// tb_control: directed walk through every instruction class of the main
// controller, comparing the full output word against hand-written values.
module tb_control;

    logic        ph1;
    logic        reset;
    logic        Zero;
    logic [31:0] Instruction;
    logic        MemWrite, MemRead, MemtoReg, PCWriteCond, PCWrite, IorD;
    logic        IRWrite0, IRWrite1, IRWrite2, IRWrite3;
    logic        RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;

    int n_cmp;
    int n_bad;

    control dut (
        .ph1         (ph1),
        .reset       (reset),
        .Zero        (Zero),
        .Instruction (Instruction),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemtoReg    (MemtoReg),
        .PCWriteCond (PCWriteCond),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .IRWrite0    (IRWrite0),
        .IRWrite1    (IRWrite1),
        .IRWrite2    (IRWrite2),
        .IRWrite3    (IRWrite3),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Output word layout (MSB first):
    // MemWrite MemRead MemtoReg PCWriteCond PCWrite IorD IRW3 IRW2 IRW1 IRW0
    // RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
    localparam logic [18:0] E_FETCH1  = 19'b0_1_0_0_1_0_1000_0_0_0_01_00_00;
    localparam logic [18:0] E_FETCH2  = 19'b0_1_0_0_1_0_0100_0_0_0_01_00_00;
    localparam logic [18:0] E_FETCH3  = 19'b0_1_0_0_1_0_0010_0_0_0_01_00_00;
    localparam logic [18:0] E_FETCH4  = 19'b0_1_0_0_1_0_0001_0_0_0_01_00_00;
    localparam logic [18:0] E_DECODE  = 19'b0_0_0_0_0_0_0000_0_0_0_11_00_00;
    localparam logic [18:0] E_MEMADR  = 19'b0_0_0_0_0_0_0000_0_0_1_10_00_00;
    localparam logic [18:0] E_LBRD    = 19'b0_1_0_0_0_1_0000_0_0_0_00_00_00;
    localparam logic [18:0] E_LBWR    = 19'b0_0_1_0_0_0_0000_0_1_0_00_00_00;
    localparam logic [18:0] E_SBWR    = 19'b1_0_0_0_0_1_0000_0_0_0_00_00_00;
    localparam logic [18:0] E_RTYPEEX = 19'b0_0_0_0_0_0_0000_0_0_1_00_10_00;
    localparam logic [18:0] E_RTYPEWR = 19'b0_0_0_0_0_0_0000_1_1_0_00_00_00;
    localparam logic [18:0] E_BEQEX   = 19'b0_0_0_1_0_0_0000_0_0_1_00_01_01;
    localparam logic [18:0] E_JEX     = 19'b0_0_0_0_1_0_0000_0_0_0_00_00_10;
    localparam logic [18:0] E_ADDIEX  = 19'b0_0_0_0_0_0_0000_0_0_1_10_00_00;
    localparam logic [18:0] E_ADDIWR  = 19'b0_0_0_0_0_0_0000_0_1_0_00_00_00;

    localparam logic [31:0] I_J     = 32'h0800_0003;
    localparam logic [31:0] I_LB    = 32'h8000_0000;
    localparam logic [31:0] I_SB    = 32'hA000_0000;
    localparam logic [31:0] I_BEQ   = 32'h1000_0000;
    localparam logic [31:0] I_RTYPE = 32'h0000_0020;
    localparam logic [31:0] I_ADDI  = 32'h2000_0000;
    localparam logic [31:0] I_ILL   = 32'hFC00_0000;

    logic [18:0] w_obs;
    assign w_obs = {MemWrite, MemRead, MemtoReg, PCWriteCond, PCWrite, IorD,
                    IRWrite3, IRWrite2, IRWrite1, IRWrite0,
                    RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // Compare the current output word against the expected one.
    task automatic check(input string tag, input logic [18:0] exp_val);
        n_cmp++;
        assert (w_obs === exp_val) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, w_obs, exp_val);
        end
        $display("check %-12s observed=%b expected=%b", tag, w_obs, exp_val);
    endtask

    // Advance one ph1 edge and compare in the middle of the low phase.
    task automatic step(input string tag, input logic [18:0] exp_val);
        @(posedge ph1);
        @(negedge ph1);
        check(tag, exp_val);
    endtask

    // Walk the four fetch cycles after FETCH1 has been checked, ending in DECODE.
    task automatic fetch_to_decode(input string pfx);
        step({pfx, "_F2"}, E_FETCH2);
        step({pfx, "_F3"}, E_FETCH3);
        step({pfx, "_F4"}, E_FETCH4);
        step({pfx, "_DEC"}, E_DECODE);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        Zero        = 1'b0;
        Instruction = I_J;

        // Reset held low across clock edges keeps FETCH1.
        #1 check("rst_hold0", E_FETCH1);
        repeat (3) @(posedge ph1);
        @(negedge ph1);
        check("rst_hold1", E_FETCH1);

        // J: 6-cycle loop, run twice.
        reset = 1'b1;
        check("j_F1", E_FETCH1);
        fetch_to_decode("j");
        step("j_JEX", E_JEX);
        step("j2_F1", E_FETCH1);
        fetch_to_decode("j2");
        step("j2_JEX", E_JEX);
        step("lb_F1", E_FETCH1);

        // LB: scramble the opcode during fetch; only the DECODE/MEMADR value matters.
        Instruction = I_ILL;
        fetch_to_decode("lb");
        Instruction = I_LB;
        step("lb_MEMADR", E_MEMADR);
        step("lb_LBRD", E_LBRD);
        Instruction = I_SB;      // changing opcode in LBRD must not matter
        step("lb_LBWR", E_LBWR);
        step("sb_F1", E_FETCH1);

        // SB.
        fetch_to_decode("sb");
        step("sb_MEMADR", E_MEMADR);
        step("sb_SBWR", E_SBWR);
        step("beq0_F1", E_FETCH1);

        // BEQ with Zero=0 then Zero=1: identical outputs.
        Instruction = I_BEQ;
        Zero = 1'b0;
        fetch_to_decode("beq0");
        step("beq0_EX", E_BEQEX);
        step("beq1_F1", E_FETCH1);
        Zero = 1'b1;
        fetch_to_decode("beq1");
        step("beq1_EX", E_BEQEX);
        Zero = 1'b0;
        #1 check("beq1_EXz", E_BEQEX);
        step("rt_F1", E_FETCH1);

        // RTYPE.
        Instruction = I_RTYPE;
        fetch_to_decode("rt");
        step("rt_EX", E_RTYPEEX);
        step("rt_WR", E_RTYPEWR);
        step("ad_F1", E_FETCH1);

        // ADDI.
        Instruction = I_ADDI;
        fetch_to_decode("ad");
        step("ad_EX", E_ADDIEX);
        step("ad_WR", E_ADDIWR);
        step("il_F1", E_FETCH1);

        // Illegal opcode: DECODE straight back to FETCH1.
        Instruction = I_ILL;
        fetch_to_decode("il");
        step("il_back", E_FETCH1);

        // Reset pulsed during LBRD aborts immediately.
        Instruction = I_LB;
        fetch_to_decode("ra");
        step("ra_MEMADR", E_MEMADR);
        step("ra_LBRD", E_LBRD);
        reset = 1'b0;
        #1 check("ra_async", E_FETCH1);
        @(posedge ph1);
        @(negedge ph1);
        check("ra_hold", E_FETCH1);
        reset = 1'b1;
        step("ra_F2", E_FETCH2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
